udma_ctrl_dp_out_buf: RTL and testbench

// - Buffer stage directly upstream of the uDMA controller data-plane output interface.
// - Accepts L2 read-response words tagged with channel ID, size and byte offset.
// - Aligns and masks each word, queues it in a FIFO, presents it to peripherals via valid/ready.
// - Decouples L2 latency from peripheral back-pressure.

---
 rtl/udma_ctrl_dp_out_buf.sv | 106 ++++++++++
 tb/tb_udma_ctrl_dp_out_buf.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/udma_ctrl_dp_out_buf.sv
// udma_ctrl_dp_out_buf: aligning/masking FIFO between L2 read responses and the uDMA data-plane output.
// Define UDMA_CTRL_DP_OUT_BUF_STATS_EN to add saturating word/stall/overflow counters.
module udma_ctrl_dp_out_buf #(
   parameter int DEPTH  = 4,
   parameter int CH_W   = 5,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clear_i,
   input  logic                     l2_rvalid_i,
   output logic                     l2_rready_o,
   input  logic [DATA_W-1:0]        l2_rdata_i,
   input  logic [CH_W-1:0]          l2_rid_i,
   input  logic [1:0]               l2_rsize_i,
   input  logic [1:0]               l2_roffs_i,
   output logic                     dp_valid_o,
   input  logic                     dp_ready_i,
   output logic [DATA_W-1:0]        dp_data_o,
   output logic [CH_W-1:0]          dp_ch_o,
   output logic [1:0]               dp_size_o,
   output logic                     dp_err_o,
   output logic [$clog2(DEPTH):0]   level_o
`ifdef UDMA_CTRL_DP_OUT_BUF_STATS_EN
   ,
   output logic [15:0]              stat_words_o,
   output logic [15:0]              stat_stall_o,
   output logic [15:0]              stat_ovf_o
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [CH_W-1:0]   ch;
      logic [1:0]        size;
      logic              err;
   } entry_t;

   entry_t            mem [DEPTH];
   entry_t            in_entry;
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [LW-1:0]     level;
   logic [DATA_W-1:0] shifted;
   logic              push, pop;

   assign push        = l2_rvalid_i && l2_rready_o;
   assign pop         = dp_valid_o && dp_ready_i;
   assign l2_rready_o = level != LW'(DEPTH);
   assign dp_valid_o  = level != '0;
   assign level_o     = level;
   assign dp_data_o   = mem[rd_ptr].data;
   assign dp_ch_o     = mem[rd_ptr].ch;
   assign dp_size_o   = mem[rd_ptr].size;
   assign dp_err_o    = mem[rd_ptr].err;

   // Reserved size 3 falls through to the full-word mask.
   always_comb begin
      shifted       = l2_rdata_i >> {l2_roffs_i, 3'b000};
      in_entry.data = l2_rsize_i == 2'd0 ? {{(DATA_W-8){1'b0}}, shifted[7:0]} :
                      l2_rsize_i == 2'd1 ? {{(DATA_W-16){1'b0}}, shifted[15:0]} : shifted;
      in_entry.ch   = l2_rid_i;
      in_entry.size = l2_rsize_i;
      in_entry.err  = l2_rsize_i == 2'd3 || (l2_rsize_i == 2'd1 && l2_roffs_i == 2'd3) ||
                      (l2_rsize_i == 2'd2 && l2_roffs_i != 2'd0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_entry;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(push) - LW'(pop);
      end
   end

`ifdef UDMA_CTRL_DP_OUT_BUF_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_words_o <= '0;
         stat_stall_o <= '0;
         stat_ovf_o   <= '0;
      end else if (clear_i) begin
         stat_words_o <= '0;
         stat_stall_o <= '0;
         stat_ovf_o   <= '0;
      end else begin
         if (pop && stat_words_o != 16'hFFFF) stat_words_o <= stat_words_o + 16'd1;
         if (dp_valid_o && !dp_ready_i && stat_stall_o != 16'hFFFF) stat_stall_o <= stat_stall_o + 16'd1;
         if (l2_rvalid_i && !l2_rready_o && stat_ovf_o != 16'hFFFF) stat_ovf_o <= stat_ovf_o + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_udma_ctrl_dp_out_buf.sv
// tb_udma_ctrl_dp_out_buf: queue-based reference model checked against the DUT every cycle.
module tb_udma_ctrl_dp_out_buf;
   localparam int DEPTH = 4;
   localparam int CH_W  = 5;

   logic            clk = 0;
   logic            reset_n = 0;
   logic            clear_i = 0;
   logic            l2_rvalid_i = 0;
   logic            l2_rready_o;
   logic [31:0]     l2_rdata_i = 0;
   logic [CH_W-1:0] l2_rid_i = 0;
   logic [1:0]      l2_rsize_i = 0;
   logic [1:0]      l2_roffs_i = 0;
   logic            dp_valid_o;
   logic            dp_ready_i = 0;
   logic [31:0]     dp_data_o;
   logic [CH_W-1:0] dp_ch_o;
   logic [1:0]      dp_size_o;
   logic            dp_err_o;
   logic [2:0]      level_o;
`ifdef UDMA_CTRL_DP_OUT_BUF_STATS_EN
   logic [15:0]     stat_words_o, stat_stall_o, stat_ovf_o;
`endif

   udma_ctrl_dp_out_buf #(.DEPTH(DEPTH), .CH_W(CH_W), .DATA_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .clear_i(clear_i),
      .l2_rvalid_i(l2_rvalid_i), .l2_rready_o(l2_rready_o), .l2_rdata_i(l2_rdata_i),
      .l2_rid_i(l2_rid_i), .l2_rsize_i(l2_rsize_i), .l2_roffs_i(l2_roffs_i),
      .dp_valid_o(dp_valid_o), .dp_ready_i(dp_ready_i), .dp_data_o(dp_data_o),
      .dp_ch_o(dp_ch_o), .dp_size_o(dp_size_o), .dp_err_o(dp_err_o), .level_o(level_o)
`ifdef UDMA_CTRL_DP_OUT_BUF_STATS_EN
      , .stat_words_o(stat_words_o), .stat_stall_o(stat_stall_o), .stat_ovf_o(stat_ovf_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]     d;
      logic [CH_W-1:0] ch;
      logic [1:0]      sz;
      logic            e;
   } ent_t;

   ent_t q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, act, exp, $time);
      end
   endtask

   // Byte-lane view: copy nbytes bytes starting at lane offs into the low lanes.
   function automatic ent_t model_entry(input logic [31:0] rd, input logic [CH_W-1:0] id,
                                        input logic [1:0] sz, input logic [1:0] of);
      ent_t r;
      int nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
      r.d = 0;
      for (int i = 0; i < nb; i++)
         if (int'(of) + i < 4) r.d[8*i +: 8] = rd[8*(int'(of)+i) +: 8];
      r.ch = id;
      r.sz = sz;
      r.e  = (sz == 3) || (int'(of) + nb > 4);
      return r;
   endfunction

   task automatic compare();
      chk("level", 32'(level_o), 32'(q.size()));
      chk("valid", 32'(dp_valid_o), 32'(q.size() != 0));
      chk("rready", 32'(l2_rready_o), 32'(q.size() < DEPTH));
      if (q.size() != 0) begin
         chk("data", dp_data_o, q[0].d);
         chk("ch", 32'(dp_ch_o), 32'(q[0].ch));
         chk("size", 32'(dp_size_o), 32'(q[0].sz));
         chk("err", 32'(dp_err_o), 32'(q[0].e));
      end
   endtask

   task automatic step(input logic v, input logic [31:0] d, input logic [CH_W-1:0] id,
                       input logic [1:0] sz, input logic [1:0] of, input logic rdy, input logic clr);
      bit acc, pop;
      l2_rvalid_i = v; l2_rdata_i = d; l2_rid_i = id; l2_rsize_i = sz; l2_roffs_i = of;
      dp_ready_i = rdy; clear_i = clr;
      acc = v && q.size() < DEPTH;
      pop = rdy && q.size() != 0;
      @(posedge clk);
      if (clr) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(model_entry(d, id, sz, of));
      end
      @(negedge clk);
      compare();
   endtask

   task automatic idle(input logic rdy);
      step(0, 0, 0, 0, 0, rdy, 0);
   endtask

   initial begin
      #12;
      chk("rst_valid", 32'(dp_valid_o), 0);
      chk("rst_level", 32'(level_o), 0);
      chk("rst_rready", 32'(l2_rready_o), 1);
      chk("rst_data", dp_data_o, 0);
      chk("rst_ch", 32'(dp_ch_o), 0);
      chk("rst_size", 32'(dp_size_o), 0);
      chk("rst_err", 32'(dp_err_o), 0);
      @(negedge clk);
      reset_n = 1;
      @(negedge clk);
      compare();

      step(1, 32'hAABBCCDD, 1, 0, 2, 0, 0);
      chk("byte_valid", 32'(dp_valid_o), 1);
      chk("byte_data", dp_data_o, 32'h000000BB);
      chk("byte_err", 32'(dp_err_o), 0);
      idle(1);
      step(1, 32'h11223344, 2, 1, 3, 0, 0);
      chk("half_data", dp_data_o, 32'h00000011);
      chk("half_err", 32'(dp_err_o), 1);
      idle(1);
      step(1, 32'hDEADBEEF, 3, 2, 0, 0, 0);
      chk("word_data", dp_data_o, 32'hDEADBEEF);
      chk("word_err", 32'(dp_err_o), 0);
      idle(1);

      for (int i = 0; i < DEPTH; i++) step(1, 32'h100 + i, CH_W'(i), 2, 0, 0, 0);
      chk("full_level", 32'(level_o), 4);
      chk("full_rready", 32'(l2_rready_o), 0);
      step(1, 32'h999, 9, 2, 0, 0, 0);
      chk("full_noacc", 32'(level_o), 4);
      for (int i = 0; i < DEPTH; i++) begin
         chk("order_ch", 32'(dp_ch_o), i);
         idle(1);
      end
      chk("drained", 32'(dp_valid_o), 0);

      for (int i = 0; i < 64; i++) begin
         step(1, 32'h5000 + i, CH_W'(i), 2, 0, 1, 0);
         chk("stream_level", 32'(level_o), 1);
         chk("stream_data", dp_data_o, 32'h5000 + i);
      end
      idle(1);

      for (int i = 0; i < 3; i++) step(1, 32'h700 + i, CH_W'(i), 2, 0, 0, 0);
      step(1, 32'h777, 7, 2, 0, 1, 1);
      chk("clr_level", 32'(level_o), 0);
      chk("clr_valid", 32'(dp_valid_o), 0);
      chk("clr_rready", 32'(l2_rready_o), 1);

`ifdef UDMA_CTRL_DP_OUT_BUF_STATS_EN
      step(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) step(1, 32'h800 + i, CH_W'(i), 2, 0, 0, 0);
      for (int i = 0; i < 7; i++) idle(0);
      for (int i = 0; i < 5; i++) step(1, 32'h900 + i, CH_W'(i), 2, 0, 1, 0);
      chk("stat_stall", 32'(stat_stall_o), 10);
      chk("stat_words", 32'(stat_words_o), 5);
      chk("stat_ovf", 32'(stat_ovf_o), 1);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("stat_stall_clr", 32'(stat_stall_o), 0);
      chk("stat_words_clr", 32'(stat_words_o), 0);
`endif

      for (int i = 0; i < 2000; i++)
         step(1'($urandom_range(0, 3) != 0), $urandom, CH_W'($urandom), 2'($urandom), 2'($urandom),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
